// File: rtl/sfp_accum_if.sv
// Handshake and job-control bundle for the multi-pass partial-sum accumulator.
// The master side drives jobs and input vectors; the slave side is the accumulator.
interface sfp_accum_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int pass_bw = 4
);
  localparam int AW = $clog2(depth);

  logic                   start;
  logic [pass_bw-1:0]     num_pass;
  logic [AW:0]            num_pos;
  logic                   relu_en;
  logic                   clear;
  logic                   in_valid;
  logic [col*psum_bw-1:0] in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [col*psum_bw-1:0] out_data;
  logic                   out_ready;
  logic                   busy;
  logic                   done;

  modport master (
    output start, num_pass, num_pos, relu_en, clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, num_pass, num_pos, relu_en, clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/sfp_accum.sv
// Multi-pass partial-sum accumulator: buffers num_pos vectors, accumulates them over
// num_pass passes with per-lane saturation, then drains them with optional ReLU.
module sfp_accum #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int pass_bw = 4
) (
  input  logic       clk,
  input  logic       reset,
  sfp_accum_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int VW = col * psum_bw;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(depth);
  localparam logic signed [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t             state;
  logic [AW-1:0]      pos;
  logic [AW-1:0]      np_last;
  logic [AW-1:0]      rd_addr;
  logic [pass_bw-1:0] pass;
  logic [pass_bw-1:0] npass_last;
  logic               relu_q;
  logic               out_valid_q;
  logic               done_q;
  logic [VW-1:0]      out_data_q;
  logic [VW-1:0]      mem [depth];
  logic [VW-1:0]      rd_word;
  logic [VW-1:0]      acc_word;
  logic [VW-1:0]      relu_word;
  logic               in_hs;

  function automatic logic signed [psum_bw-1:0] sat_add(
    input logic signed [psum_bw-1:0] a,
    input logic signed [psum_bw-1:0] b
  );
    logic signed [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1]) return s[psum_bw] ? SAT_MIN : SAT_MAX;
    return s[psum_bw-1:0];
  endfunction

  function automatic logic signed [psum_bw-1:0] relu(
    input logic signed [psum_bw-1:0] v,
    input logic                      en
  );
    return (en && v[psum_bw-1]) ? '0 : v;
  endfunction

  assign bus.in_ready  = (state == ACC);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;

  assign in_hs = bus.in_valid && (state == ACC) && !bus.clear;

  // Single read port: the RMW operand in ACC, the next entry to present in DRAIN.
  assign rd_addr = (state == DRAIN && out_valid_q) ? pos + 1'b1 : pos;
  assign rd_word = mem[rd_addr];

  always_comb begin
    logic signed [psum_bw-1:0] lane_m;
    logic signed [psum_bw-1:0] lane_i;
    acc_word  = '0;
    relu_word = '0;
    for (int k = 0; k < col; k++) begin
      lane_m = rd_word[k*psum_bw +: psum_bw];
      lane_i = bus.in_data[k*psum_bw +: psum_bw];
      acc_word[k*psum_bw +: psum_bw]  = (pass == '0) ? lane_i : sat_add(lane_m, lane_i);
      relu_word[k*psum_bw +: psum_bw] = relu(lane_m, relu_q);
    end
  end

  // Storage is never reset: pass 0 overwrites every entry before anything is drained.
  always_ff @(posedge clk) begin
    if (in_hs) mem[pos] <= acc_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pos         <= '0;
      pass        <= '0;
      np_last     <= '0;
      npass_last  <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else if (bus.clear) begin
      state       <= IDLE;
      pos         <= '0;
      pass        <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (bus.num_pos == '0 || bus.num_pos > DEPTH_V) np_last <= AW'(depth - 1);
            else                                           np_last <= AW'(bus.num_pos - 1'b1);
            npass_last <= (bus.num_pass == '0) ? '0 : bus.num_pass - 1'b1;
            relu_q     <= bus.relu_en;
            pos        <= '0;
            pass       <= '0;
            state      <= ACC;
          end
        end
        ACC: begin
          if (in_hs) begin
            if (pos == np_last) begin
              pos <= '0;
              if (pass == npass_last) state <= DRAIN;
              else                    pass  <= pass + 1'b1;
            end else begin
              pos <= pos + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!out_valid_q) begin
            out_data_q  <= relu_word;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            if (pos == np_last) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state       <= DONE;
            end else begin
              pos        <= pos + 1'b1;
              out_data_q <= relu_word;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sfp_accum.sv
// Randomized scoreboard bench for sfp_accum: a lane-level arithmetic model predicts every
// drained vector; a monitor pops and compares on each output handshake.
module tb_sfp_accum;
  localparam int COL = 8, W = 16, DEPTH = 16, PBW = 4, VW = COL * W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfp_accum_if #(.col(COL), .psum_bw(W), .depth(DEPTH), .pass_bw(PBW)) bus();

  sfp_accum #(.col(COL), .psum_bw(W), .depth(DEPTH), .pass_bw(PBW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] mon_e;
  logic [VW-1:0] prev_data;
  bit            prev_stall = 1'b0;
  bit            out_rand = 1'b0;
  int            vin[16][16][COL];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, expv);
    end
  endtask

  task automatic chki(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, expv);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=timeout want=event", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Output monitor: compare on every handshake, and check hold-stability during stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.done) done_cnt++;
        if (prev_stall) begin
          chki("stall_valid", int'(bus.out_valid), 1);
          chk("stall_data", bus.out_data, prev_data);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_extra got=%h want=none", bus.out_data);
          end else begin
            mon_e = exp_q.pop_front();
            chk("out_data", bus.out_data, mon_e);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = out_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  function automatic int gen_val(input int mode, input int q, input int l);
    int r;
    r = int'($urandom_range(0, 65535)) - 32768;
    case (mode)
      1: return (l == 0) ? q + 1 : -(q + 1);
      2: return 100;
      3: return (l == 0) ? 30000 : (l == 1) ? -30000 : r;
      4: case (l)
           0: return -5;
           1: return 0;
           2: return 7;
           3: return -32768;
           default: return r;
         endcase
      default: return r;
    endcase
  endfunction

  task automatic feed_vec(input int p, input int q, input bit gap, inout int ir_cycles);
    logic [VW-1:0] vec;
    bit hs;
    int k;
    for (int l = 0; l < COL; l++) vec[l*W +: W] = W'(vin[p][q][l]);
    bus.in_data = vec;
    hs = 1'b0;
    k  = 0;
    while (!hs) begin
      bus.in_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.in_ready) ir_cycles++;
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      k++;
      if (k > 200) timeout("in_handshake");
    end
  endtask

  task automatic start_job(input int npass, input int npos, input bit relu);
    bus.start    = 1'b1;
    bus.num_pass = PBW'(npass);
    bus.num_pos  = 5'(npos);
    bus.relu_en  = relu;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_job(input int npass, input int npos, input bit relu, input int mode,
                         input bit gap, input bit rst_drain);
    int ep, epass, s, ir_cycles, k;
    logic [VW-1:0] e;
    ep    = (npos == 0 || npos > DEPTH) ? DEPTH : npos;
    epass = (npass == 0) ? 1 : npass;
    for (int p = 0; p < epass; p++)
      for (int q = 0; q < ep; q++)
        for (int l = 0; l < COL; l++) vin[p][q][l] = gen_val(mode, q, l);
    for (int q = 0; q < ep; q++) begin
      for (int l = 0; l < COL; l++) begin
        s = vin[0][q][l];
        for (int p = 1; p < epass; p++) begin
          s = s + vin[p][q][l];
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
        end
        if (relu && s < 0) s = 0;
        e[l*W +: W] = W'(s);
      end
      exp_q.push_back(e);
    end
    out_rand = gap;
    start_job(npass, npos, relu);
    ir_cycles = 0;
    for (int p = 0; p < epass; p++)
      for (int q = 0; q < ep; q++) feed_vec(p, q, gap, ir_cycles);
    bus.in_valid = 1'b0;
    chki("in_ready_after_last", int'(bus.in_ready), 0);
    if (!gap) chki("in_ready_cycles", ir_cycles, epass * ep);
    if (rst_drain) begin
      k = 0;
      while (!bus.out_valid) begin
        @(posedge clk);
        #1;
        k++;
        if (k > 50) timeout("drain_valid");
      end
      reset = 1'b1;
      #1;
      chki("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", bus.out_data, '0);
      chki("rst_in_ready", int'(bus.in_ready), 0);
      chki("rst_busy", int'(bus.busy), 0);
      chki("rst_done", int'(bus.done), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
    end else begin
      k = 0;
      while (!bus.done) begin
        @(posedge clk);
        #1;
        k++;
        if (k > 2000) timeout("done_wait");
      end
      if (!gap) chki("drain_cycles", k, ep + 1);
      chki("exp_empty_at_done", exp_q.size(), 0);
      chki("busy_in_done", int'(bus.busy), 1);
      @(posedge clk);
      #1;
      chki("done_one_cycle", int'(bus.done), 0);
      chki("busy_after_done", int'(bus.busy), 0);
    end
    out_rand = 1'b0;
  endtask

  task automatic abort_job();
    int ir_cycles, d0;
    ir_cycles = 0;
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < 4; q++)
        for (int l = 0; l < COL; l++) vin[p][q][l] = gen_val(0, q, l);
    start_job(3, 4, 1'b0);
    for (int q = 0; q < 4; q++) feed_vec(0, q, 1'b0, ir_cycles);
    feed_vec(1, 0, 1'b0, ir_cycles);
    bus.in_valid = 1'b1;
    bus.clear    = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    chki("clear_busy", int'(bus.busy), 0);
    chki("clear_in_ready", int'(bus.in_ready), 0);
    repeat (5) @(posedge clk);
    #1;
    chki("clear_no_done", done_cnt, d0);
    chki("clear_no_out_valid", int'(bus.out_valid), 0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.num_pass = '0;
    bus.num_pos  = '0;
    bus.relu_en  = 1'b0;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chki("reset_in_ready", int'(bus.in_ready), 0);
    chki("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", bus.out_data, '0);
    chki("reset_busy", int'(bus.busy), 0);
    chki("reset_done", int'(bus.done), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_job(1, 4, 1'b0, 1, 1'b0, 1'b0);
    run_job(3, 2, 1'b0, 2, 1'b0, 1'b0);
    run_job(2, 2, 1'b0, 3, 1'b0, 1'b0);
    run_job(1, 1, 1'b1, 4, 1'b0, 1'b0);
    run_job(2, 16, 1'b0, 0, 1'b1, 1'b0);
    run_job(2, 0, 1'b0, 0, 1'b1, 1'b0);
    run_job(1, 5, 1'b1, 0, 1'b1, 1'b0);
    run_job(1, 20, 1'b0, 0, 1'b0, 1'b0);
    run_job(0, 3, 1'b0, 0, 1'b0, 1'b0);
    abort_job();
    run_job(2, 8, 1'b0, 0, 1'b0, 1'b0);
    run_job(2, 6, 1'b0, 0, 1'b0, 1'b1);
    run_job(1, 3, 1'b0, 0, 1'b0, 1'b0);
    run_job(3, 16, 1'b1, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
